led_sequencer: RTL and testbench

Parametrised multi-channel LED sequencer: the successor to the single-period blinkers used for board bring-up. It runs from one clock and derives a shared tick from a prescaler. Each channel independently shows one of four modes (off, on, blink, blink-code) with per-channel PWM brightness. Channels are configured through a valid/ready port that applies new settings only on tick boundaries, so patterns never glitch mid-phase.

---
 rtl/led_pkg.sv | 31 +++
 rtl/led_sequencer_if.sv | 22 ++
 rtl/led_channel.sv | 105 ++++++++++
 rtl/led_sequencer.sv | 107 ++++++++++
 tb/tb_led_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared encodings and helpers for the LED sequencer and its channels.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CODE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_STATIC = 2'd0,
    ST_ON_PH  = 2'd1,
    ST_OFF_PH = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int GAP_MULT = 4;
  localparam int PH_W     = 10;
  localparam int BLK_W    = 4;

  // A zero half-period or count behaves as one.
  function automatic logic [PH_W-1:0] clamp_half(input logic [7:0] half);
    return (half == 8'd0) ? PH_W'(1) : {2'b00, half};
  endfunction

  function automatic logic [BLK_W-1:0] clamp_count(input logic [BLK_W-1:0] count);
    return (count == '0) ? BLK_W'(1) : count;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Configuration port of the LED sequencer: one valid/ready transfer per channel setting.
interface led_sequencer_if #(
  parameter int PWM_BITS = 4
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_chan;
  logic [1:0]          cfg_mode;
  logic [7:0]          cfg_half;
  logic [3:0]          cfg_count;
  logic [PWM_BITS-1:0] cfg_duty;

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_half, cfg_count, cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_half, cfg_count, cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/led_channel.sv
// One LED channel: holds its configuration, steps the blink/code FSM on ticks
// and gates the pattern with the shared PWM counter.
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 4
) (
  input  logic                clk_12mhz,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                apply_i,
  input  mode_e               mode_i,
  input  logic [7:0]          half_i,
  input  logic [3:0]          count_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] wcnt_i,
  output logic                lit_o
);

  mode_e               mode_q;
  logic [7:0]          half_q;
  logic [BLK_W-1:0]    count_q;
  logic [PWM_BITS-1:0] duty_q;
  state_e              state_q;
  logic [PH_W-1:0]     ph_q;
  logic [BLK_W-1:0]    blk_q;

  logic [PH_W-1:0]     h;
  logic [PH_W-1:0]     ph_last;
  logic [PH_W-1:0]     gap_last;
  logic [BLK_W-1:0]    blk_last;
  logic                pattern;
  logic                pwm_on;

  always_comb begin
    h        = clamp_half(half_q);
    ph_last  = h - PH_W'(1);
    gap_last = PH_W'(GAP_MULT) * h - PH_W'(1);
    blk_last = clamp_count(count_q) - BLK_W'(1);
    pattern  = 1'b0;
    case (state_q)
      ST_STATIC: pattern = (mode_q == MODE_ON);
      ST_ON_PH:  pattern = 1'b1;
      default:   pattern = 1'b0;
    endcase
    // All-ones duty is full-on rather than one step short of it.
    pwm_on = (&duty_q) | (wcnt_i < duty_q);
    lit_o  = pattern & pwm_on;
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      half_q  <= '0;
      count_q <= '0;
      duty_q  <= '0;
      state_q <= ST_STATIC;
      ph_q    <= '0;
      blk_q   <= '0;
    end else if (apply_i) begin
      mode_q  <= mode_i;
      half_q  <= half_i;
      count_q <= count_i;
      duty_q  <= duty_i;
      ph_q    <= '0;
      blk_q   <= '0;
      state_q <= (mode_i == MODE_BLINK || mode_i == MODE_CODE) ? ST_ON_PH : ST_STATIC;
    end else if (tick_i) begin
      case (state_q)
        ST_ON_PH: begin
          if (ph_q == ph_last) begin
            ph_q    <= '0;
            state_q <= ST_OFF_PH;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        ST_OFF_PH: begin
          if (ph_q == ph_last) begin
            ph_q <= '0;
            if (mode_q == MODE_CODE && blk_q == blk_last) begin
              blk_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              blk_q   <= (mode_q == MODE_CODE) ? blk_q + BLK_W'(1) : '0;
              state_q <= ST_ON_PH;
            end
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        ST_GAP: begin
          if (ph_q == gap_last) begin
            ph_q    <= '0;
            state_q <= ST_ON_PH;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: shared tick prescaler and PWM counter, a single
// config staging slot applied on tick boundaries, and registered LED outputs.
module led_sequencer
  import led_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 100,
  parameter int CHANNELS = 2,
  parameter int PWM_BITS = 4
) (
  input  logic                clk_12mhz,
  input  logic                rst,
  led_sequencer_if.slave      cfg,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] wcnt_q;

  logic                stg_full_q;
  logic [3:0]          stg_chan_q;
  mode_e               stg_mode_q;
  logic [7:0]          stg_half_q;
  logic [3:0]          stg_count_q;
  logic [PWM_BITS-1:0] stg_duty_q;

  logic                accept;
  logic                apply;
  logic [CHANNELS-1:0] apply_vec;
  logic [CHANNELS-1:0] lit;
  logic [CHANNELS-1:0] led_q;

  // tick_q is high exactly while pcnt_q sits at DIV-1.
  always_comb begin
    pcnt_d = (pcnt_q == PCNT_W'(DIV - 1)) ? '0 : pcnt_q + PCNT_W'(1);
    tick_d = (pcnt_d == PCNT_W'(DIV - 1));
    accept = cfg.cfg_valid & ~stg_full_q;
    apply  = stg_full_q & tick_q;
  end

  assign cfg.cfg_ready = ~stg_full_q;
  assign tick          = tick_q;
  assign led           = led_q;

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
      wcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
      wcnt_q <= wcnt_q + PWM_BITS'(1);
    end
  end

  // A staged request is only ever released by a tick seen after it was accepted.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      stg_full_q  <= 1'b0;
      stg_chan_q  <= '0;
      stg_mode_q  <= MODE_OFF;
      stg_half_q  <= '0;
      stg_count_q <= '0;
      stg_duty_q  <= '0;
    end else if (accept) begin
      stg_full_q  <= 1'b1;
      stg_chan_q  <= cfg.cfg_chan;
      stg_mode_q  <= mode_e'(cfg.cfg_mode);
      stg_half_q  <= cfg.cfg_half;
      stg_count_q <= cfg.cfg_count;
      stg_duty_q  <= cfg.cfg_duty;
    end else if (apply) begin
      stg_full_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign apply_vec[i] = apply & (stg_chan_q == 4'(i));

    led_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk_12mhz (clk_12mhz),
      .rst       (rst),
      .tick_i    (tick_q),
      .apply_i   (apply_vec[i]),
      .mode_i    (stg_mode_q),
      .half_i    (stg_half_q),
      .count_i   (stg_count_q),
      .duty_i    (stg_duty_q),
      .wcnt_i    (wcnt_q),
      .lit_o     (lit[i])
    );
  end

  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= lit;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: a tick-count reference model fills a scoreboard each
// edge, the opposite edge pops and compares, and directed steps measure patterns.
module tb_led_sequencer;
  import led_pkg::*;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = 10;
  localparam int CH      = 2;
  localparam int PW      = 4;

  logic          clk;
  logic          rst;
  logic          tick;
  logic [CH-1:0] led;

  led_sequencer_if #(.PWM_BITS(PW)) bus ();

  led_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .CHANNELS (CH),
    .PWM_BITS (PW)
  ) dut (
    .clk_12mhz (clk),
    .rst       (rst),
    .cfg       (bus),
    .tick      (tick),
    .led       (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [CH-1:0] led;
    logic          tick;
    logic          rdy;
  } exp_t;

  exp_t sbq[$];

  int m_pcnt, m_wcnt;
  bit m_full;
  int s_chan, s_mode, s_half, s_count, s_duty;
  int m_mode[CH], m_h[CH], m_n[CH], m_duty[CH], m_t[CH];

  // Pattern from ticks elapsed since the last apply.
  function automatic bit m_pat(input int c);
    int h, n, per, p;
    h = m_h[c];
    n = m_n[c];
    case (m_mode[c])
      1: return 1'b1;
      2: return (m_t[c] % (2 * h)) < h;
      3: begin
        per = 2 * h * n + 4 * h;
        p   = m_t[c] % per;
        return (p < 2 * h * n) && ((p % (2 * h)) < h);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    bit   mtick, oldfull;
    int   ac;
    if (rst) begin
      m_pcnt = 0;
      m_wcnt = 0;
      m_full = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_h[c] = 1; m_n[c] = 1; m_duty[c] = 0; m_t[c] = 0;
      end
      e.led = '0; e.tick = 1'b0; e.rdy = 1'b1;
      sbq.delete();
      sbq.push_back(e);
      return;
    end
    mtick = (m_pcnt == DIV - 1);
    for (int c = 0; c < CH; c++)
      e.led[c] = m_pat(c) && (m_duty[c] == 15 || m_wcnt < m_duty[c]);
    oldfull = m_full;
    ac = -1;
    if (oldfull && mtick) begin
      m_full = 0;
      if (s_chan < CH) begin
        m_mode[s_chan] = s_mode;
        m_h[s_chan]    = (s_half == 0) ? 1 : s_half;
        m_n[s_chan]    = (s_count == 0) ? 1 : s_count;
        m_duty[s_chan] = s_duty;
        m_t[s_chan]    = 0;
        ac = s_chan;
      end
    end
    for (int c = 0; c < CH; c++)
      if (mtick && c != ac) m_t[c]++;
    if (!oldfull && bus.cfg_valid) begin
      m_full  = 1;
      s_chan  = int'(bus.cfg_chan);
      s_mode  = int'(bus.cfg_mode);
      s_half  = int'(bus.cfg_half);
      s_count = int'(bus.cfg_count);
      s_duty  = int'(bus.cfg_duty);
    end
    m_pcnt = mtick ? 0 : m_pcnt + 1;
    m_wcnt = (m_wcnt + 1) % 16;
    e.tick = (m_pcnt == DIV - 1);
    e.rdy  = !m_full;
    sbq.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (!rst) begin
        chk("sb_led", 32'(led), 32'(e.led));
        chk("sb_tick", 32'(tick), 32'(e.tick));
        chk("sb_ready", 32'(bus.cfg_ready), 32'(e.rdy));
      end
    end
  end

  task automatic drive_fields(input logic [3:0] ch, input logic [1:0] md, input logic [7:0] hf,
                              input logic [3:0] cn, input logic [3:0] dt);
    bus.cfg_chan  = ch;
    bus.cfg_mode  = md;
    bus.cfg_half  = hf;
    bus.cfg_count = cn;
    bus.cfg_duty  = dt;
  endtask

  task automatic send_cfg(input logic [3:0] ch, input logic [1:0] md, input logic [7:0] hf,
                          input logic [3:0] cn, input logic [3:0] dt);
    int w;
    @(negedge clk);
    drive_fields(ch, md, hf, cn, dt);
    bus.cfg_valid = 1'b1;
    w = 0;
    while (!bus.cfg_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 32'(bus.cfg_ready), 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic run_len(input int c, input logic v, output int len);
    int w;
    w = 0;
    while (led[c] === v && w < 400) begin @(negedge clk); w++; end
    w = 0;
    while (led[c] !== v && w < 400) begin @(negedge clk); w++; end
    len = 0;
    while (led[c] === v && len < 400) begin @(negedge clk); len++; end
  endtask

  initial begin
    int cnt, len, w, maxlow, maxhigh, runlo, runhi, hi;
    logic found;

    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    drive_fields(4'd0, 2'd0, 8'd0, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    chk("reset_led", 32'(led), 0);
    chk("reset_ready", 32'(bus.cfg_ready), 1);
    chk("reset_tick", 32'(tick), 0);
    rst = 1'b0;

    cnt = 1;
    while (!tick && cnt < 30) begin @(negedge clk); cnt++; end
    chk("first_tick_cycle", cnt, 10);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!tick && cnt < 30);
    chk("tick_period", cnt, 10);

    // BLINK on ch0: 20 cycles lit, 20 dark.
    send_cfg(4'd0, MODE_BLINK, 8'd2, 4'd0, 4'd15);
    run_len(0, 1'b1, len);
    chk("blink_high", len, 20);
    run_len(0, 1'b0, len);
    chk("blink_low", len, 20);
    chk("blink_ch1_dark", 32'(led[1]), 0);

    // CODE on ch1: three 10/10 pulses then a 40-cycle gap.
    send_cfg(4'd1, MODE_CODE, 8'd1, 4'd3, 4'd15);
    repeat (15) @(negedge clk);
    maxlow = 0; maxhigh = 0; runlo = 0; runhi = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (led[1]) begin runhi++; runlo = 0; end
      else        begin runlo++; runhi = 0; end
      if (runlo > maxlow)  maxlow  = runlo;
      if (runhi > maxhigh) maxhigh = runhi;
    end
    chk("code_max_high", maxhigh, 10);
    chk("code_max_low", maxlow, 50);

    // Back-to-back configs; the second targets a channel that does not exist.
    send_cfg(4'd0, MODE_ON, 8'd0, 4'd0, 4'd4);
    chk("busy_after_accept", 32'(bus.cfg_ready), 0);
    send_cfg(4'd5, MODE_ON, 8'd0, 4'd0, 4'd15);
    repeat (25) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    chk("pwm_duty4", hi, 4);

    send_cfg(4'd0, MODE_ON, 8'd0, 4'd0, 4'd0);
    repeat (25) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    chk("pwm_duty0", hi, 0);

    // Accept in a tick cycle: the slot stays busy for a whole tick period.
    w = 0;
    while (!(bus.cfg_ready && tick) && w < 50) begin @(negedge clk); w++; end
    found = bus.cfg_ready & tick;
    chk("tick_accept_sync", 32'(found), 1);
    drive_fields(4'd0, MODE_BLINK, 8'd2, 4'd0, 4'd15);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    cnt = 0;
    while (!bus.cfg_ready && cnt < 50) begin cnt++; @(negedge clk); end
    chk("tick_accept_ready_low", cnt, 10);

    // Reconfigure ch0 while dark in OFF_PH; it must restart with a full ON_PH.
    w = 0;
    while (led[0] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    w = 0;
    while (led[0] !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    send_cfg(4'd0, MODE_BLINK, 8'd2, 4'd0, 4'd15);
    run_len(0, 1'b1, len);
    chk("restart_on_ph", len, 20);

    // Reset while ch1 is lit mid-CODE with a config sitting in the staging slot.
    w = 0;
    while (led[1] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    chk("code_lit_before_reset", 32'(led[1]), 1);
    drive_fields(4'd0, MODE_ON, 8'd0, 4'd0, 4'd15);
    bus.cfg_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    #1;
    chk("midrst_led", 32'(led), 0);
    chk("midrst_ready", 32'(bus.cfg_ready), 1);
    chk("midrst_tick", 32'(tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("staged_lost_led", 32'(led), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
